fft_frame_ctrl: RTL

// - Frame-level sequencer for the streaming FFT accelerator: one frame = RX -> CALC -> TX.
// - Handshakes with the AXIS slave IF (input capture), the FFT core and the AXIS master IF (output drain).
// - Owns the select of the shared sample-memory port; exactly one client drives it at any time.
// - Provides a per-stage watchdog, a frame counter and a frame-done interrupt for the PS-side driver.

---
 rtl/fft_frame_ctrl_pkg.sv | 18 +
 rtl/fft_frame_if.sv | 28 ++
 rtl/fft_frame_ctrl_wdt.sv | 37 +++
 rtl/fft_frame_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types for the streaming FFT frame controller:
// FSM state encoding and sample-memory owner codes.
package axi_stream_pckg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RX   = 3'd1,
        CALC = 3'd2,
        TX   = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } fft_ctrl_state_t;

    localparam logic [1:0] MEM_OWN_RX  = 2'd0;
    localparam logic [1:0] MEM_OWN_FFT = 2'd1;
    localparam logic [1:0] MEM_OWN_TX  = 2'd2;

endpackage

// File: rtl/fft_frame_if.sv
// Handshake bundle between the frame controller and the
// AXIS slave IF, the FFT core and the AXIS master IF.
interface fft_frame_if;

    logic       rx_ready;
    logic       rx_done;
    logic       s_axis_if_busy;
    logic       fft_start;
    logic       fft_done;
    logic       fft_busy;
    logic       tx_ready;
    logic       tx_done;
    logic       m_axis_if_busy;
    logic [1:0] mem_sel;

    modport master (
        output rx_ready, fft_start, tx_ready, mem_sel,
        input  rx_done, s_axis_if_busy, fft_done,
        input  fft_busy, tx_done, m_axis_if_busy
    );

    modport slave (
        input  rx_ready, fft_start, tx_ready, mem_sel,
        output rx_done, s_axis_if_busy, fft_done,
        output fft_busy, tx_done, m_axis_if_busy
    );

endinterface

// File: rtl/fft_frame_ctrl_wdt.sv
// Per-stage watchdog: counts enabled cycles since the last clear
// and flags expiry on the cycle that completes the limit.
module fft_stage_wdt #(
    parameter int WDT_WDT = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [WDT_WDT-1:0] limit_i,
    output logic               expired_o
);

    localparam logic [WDT_WDT-1:0] ONE = 1;

    logic [WDT_WDT-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // cnt_q is 0 in the entry cycle, so limit-1 is the last allowed cycle
    assign expired_o = en_i && (limit_i != '0)
                       && (cnt_q >= limit_i - ONE);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer RX -> CALC -> TX with watchdog, frame counter
// and frame-done interrupt; every output is registered.
module fft_frame_ctrl
    import axi_stream_pckg::*;
#(
    parameter int WDT_WDT  = 32,
    parameter int FCNT_WDT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ctrl_en,
    input  logic                ctrl_continuous,
    input  logic                ctrl_soft_rst,
    input  logic [WDT_WDT-1:0]  timeout_cycles,
    fft_frame_if.master         bus,
    output logic [2:0]          ctrl_state,
    output logic [FCNT_WDT-1:0] frame_cnt,
    output logic                err_timeout,
    output logic [1:0]          err_stage,
    output logic                irq
);

    localparam logic [FCNT_WDT-1:0] FCNT_ONE = 1;

    fft_ctrl_state_t     state_q, state_d;
    logic                rx_ready_q, rx_ready_d;
    logic                fft_start_q, fft_start_d;
    logic                tx_ready_q, tx_ready_d;
    logic [1:0]          mem_sel_q, mem_sel_d;
    logic [FCNT_WDT-1:0] fcnt_q, fcnt_d;
    logic                err_q, err_d;
    logic [1:0]          err_stage_q, err_stage_d;
    logic                irq_q, irq_d;
    logic                tx_done_q;
    logic                tx_rise;
    logic                start_ok;
    logic                enter;
    logic                in_stage;
    logic                wdt_exp;

    assign tx_rise  = bus.tx_done & ~tx_done_q;
    assign start_ok = ctrl_en & ~bus.s_axis_if_busy
                      & ~bus.fft_busy & ~bus.m_axis_if_busy;
    assign in_stage = (state_q == RX) || (state_q == CALC)
                      || (state_q == TX);

    fft_stage_wdt #(
        .WDT_WDT (WDT_WDT)
    ) u_wdt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (enter),
        .en_i      (in_stage),
        .limit_i   (timeout_cycles),
        .expired_o (wdt_exp)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_ok) state_d = RX;
            RX: begin
                if (bus.rx_done)  state_d = CALC;
                else if (wdt_exp) state_d = ERR;
            end
            CALC: begin
                if (bus.fft_done) state_d = TX;
                else if (wdt_exp) state_d = ERR;
            end
            TX: begin
                if (tx_rise)      state_d = DONE;
                else if (wdt_exp) state_d = ERR;
            end
            DONE: state_d = (ctrl_en && ctrl_continuous) ? RX : IDLE;
            ERR:  state_d = ERR;
            default: state_d = IDLE;
        endcase
        if (ctrl_soft_rst)
            state_d = IDLE;

        enter       = (state_d != state_q);
        rx_ready_d  = enter && (state_d == RX);
        fft_start_d = enter && (state_d == CALC);
        tx_ready_d  = enter && (state_d == TX);
        irq_d       = enter && ((state_d == DONE) || (state_d == ERR));

        fcnt_d = fcnt_q;
        if (enter && (state_d == DONE))
            fcnt_d = fcnt_q + FCNT_ONE;

        err_d       = err_q;
        err_stage_d = err_stage_q;
        if (enter && (state_d == ERR)) begin
            err_d       = 1'b1;
            err_stage_d = mem_sel_q;
        end
        if (ctrl_soft_rst) begin
            err_d       = 1'b0;
            err_stage_d = MEM_OWN_RX;
        end

        unique case (state_d)
            CALC:    mem_sel_d = MEM_OWN_FFT;
            TX:      mem_sel_d = MEM_OWN_TX;
            ERR:     mem_sel_d = mem_sel_q;
            default: mem_sel_d = MEM_OWN_RX;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rx_ready_q  <= 1'b0;
            fft_start_q <= 1'b0;
            tx_ready_q  <= 1'b0;
            mem_sel_q   <= MEM_OWN_RX;
            fcnt_q      <= '0;
            err_q       <= 1'b0;
            err_stage_q <= MEM_OWN_RX;
            irq_q       <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= rx_ready_d;
            fft_start_q <= fft_start_d;
            tx_ready_q  <= tx_ready_d;
            mem_sel_q   <= mem_sel_d;
            fcnt_q      <= fcnt_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
            irq_q       <= irq_d;
            tx_done_q   <= bus.tx_done;
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.fft_start = fft_start_q;
    assign bus.tx_ready  = tx_ready_q;
    assign bus.mem_sel   = mem_sel_q;
    assign ctrl_state    = state_q;
    assign frame_cnt     = fcnt_q;
    assign err_timeout   = err_q;
    assign err_stage     = err_stage_q;
    assign irq           = irq_q;

endmodule
